// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Load/store sequencer between the processor control unit and a data memory
// with a registered read port. One operation is accepted per request:
//   LOAD  : read addr, return the value on rdata
//   STORE : write wdata to addr
//   INC   : read addr, write back value+1, return the written value and carry
//   op=11 : illegal, completes immediately with err and no memory access
//
// State sequence after the accepting edge:
//   LOAD  : RD -> CAP -> DONE
//   STORE : WR -> DONE
//   INC   : RD -> CAP -> WR -> DONE
//   bad   : DONE
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req, op, addr,    request handshake; sampled only while ready=1
//   wdata
//   ready             idle, a request this cycle will be accepted
//   done              one-cycle completion pulse
//   rdata, carry      result of last LOAD/INC, held until the next completion
//   err               illegal op flag, valid with done, cleared on next accept
//   mem_read_en,      memory strobes, decoded from state only
//   mem_write_en
//   mem_addr,         memory address / write data; latched values outside
//   mem_datain        IDLE, zero in IDLE
//   mem_dataout       memory read data, valid only the cycle after read_en
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              carry,
    output logic              err,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_dataout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_INC   = 2'b10;

    state_t            state_q;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    // Holds the latched store data, and for INC is overwritten in CAP with the
    // incremented value (the "work" value) so WR always drives this register.
    logic [DATA_W-1:0] datain_q;
    logic [DATA_W-1:0] rdata_q;
    logic              carry_q;
    logic              err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_LOAD;
            addr_q   <= '0;
            datain_q <= '0;
            rdata_q  <= '0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        op_q     <= op;
                        addr_q   <= addr;
                        datain_q <= wdata;
                        err_q    <= 1'b0;
                        case (op)
                            OP_LOAD,
                            OP_INC:   state_q <= S_RD;
                            OP_STORE: state_q <= S_WR;
                            default: begin
                                err_q   <= 1'b1;
                                state_q <= S_DONE;
                            end
                        endcase
                    end
                end

                S_RD: begin
                    state_q <= S_CAP;
                end

                // Memory read data is only valid in this cycle.
                S_CAP: begin
                    if (op_q == OP_INC) begin
                        datain_q <= mem_dataout + 1'b1;
                        carry_q  <= &mem_dataout;
                        state_q  <= S_WR;
                    end else begin
                        rdata_q  <= mem_dataout;
                        carry_q  <= 1'b0;
                        state_q  <= S_DONE;
                    end
                end

                S_WR: begin
                    if (op_q == OP_INC) begin
                        rdata_q <= datain_q;
                    end else begin
                        carry_q <= 1'b0;
                    end
                    state_q <= S_DONE;
                end

                S_DONE: begin
                    // Leaving for IDLE: the memory bus returns to zero.
                    addr_q   <= '0;
                    datain_q <= '0;
                    state_q  <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes and ready are gated by rst so a reset edge can never commit a
    // write or accept a request.
    assign ready        = (state_q == S_IDLE) && !rst;
    assign mem_read_en  = (state_q == S_RD)   && !rst;
    assign mem_write_en = (state_q == S_WR)   && !rst;
    assign done         = (state_q == S_DONE);

    assign mem_addr     = addr_q;
    assign mem_datain   = datain_q;
    assign rdata        = rdata_q;
    assign carry        = carry_q;
    assign err          = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [1:0] op;
    logic [3:0] addr;
    logic [3:0] wdata;
    logic       ready;
    logic       done;
    logic [3:0] rdata;
    logic       carry;
    logic       err;
    logic       mem_read_en;
    logic       mem_write_en;
    logic [3:0] mem_addr;
    logic [3:0] mem_datain;
    logic [3:0] mem_dataout;

    int checks = 0;
    int errors = 0;

    // Memory model: registered read, zero when not reading.
    logic [3:0] ram [16];
    logic       pre_en;
    logic [3:0] pre_addr;
    logic [3:0] pre_data;

    always @(posedge clk) begin
        if (pre_en) ram[pre_addr] <= pre_data;
        else if (mem_write_en) ram[mem_addr] <= mem_datain;
        mem_dataout <= mem_read_en ? ram[mem_addr] : 4'h0;
    end

    // Strobe monitor.
    int rd_cnt = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    logic [3:0] last_wr_addr = 4'h0;
    logic [3:0] last_wr_data = 4'h0;

    always @(negedge clk) begin
        checks++;
        assert (!(mem_read_en && mem_write_en)) else begin
            errors++;
            $error("FAIL rw_overlap: read_en=%0b write_en=%0b required not both 1",
                   mem_read_en, mem_write_en);
        end
        if (mem_read_en) rd_cnt++;
        if (done) done_cnt++;
        if (mem_write_en) begin
            wr_cnt++;
            last_wr_addr = mem_addr;
            last_wr_data = mem_datain;
        end
    end

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(4), .DATA_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .op           (op),
        .addr         (addr),
        .wdata        (wdata),
        .ready        (ready),
        .done         (done),
        .rdata        (rdata),
        .carry        (carry),
        .err          (err),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_addr     (mem_addr),
        .mem_datain   (mem_datain),
        .mem_dataout  (mem_dataout)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preset(input logic [3:0] a, input logic [3:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_en   = 1'b0;
    endtask

    // Issue one operation from an IDLE cycle and check it to completion.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [3:0] a,
                          input logic [3:0] w, input int lat, input logic [3:0] exp_rd,
                          input logic exp_carry, input logic exp_err,
                          input int exp_rds, input int exp_wrs);
        int rd0;
        int wr0;
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        req   = 1'b1;
        op    = o;
        addr  = a;
        wdata = w;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        tick();
        req = 1'b0;
        for (int i = 1; i <= lat; i++) begin
            if (i < lat) begin
                chk({tag, "_early_done"}, 32'(done), 32'd0);
                chk({tag, "_busy"}, 32'(ready), 32'd0);
                tick();
            end else begin
                chk({tag, "_done"}, 32'(done), 32'd1);
                chk({tag, "_rdata"}, 32'(rdata), 32'(exp_rd));
                chk({tag, "_carry"}, 32'(carry), 32'(exp_carry));
                chk({tag, "_err"}, 32'(err), 32'(exp_err));
            end
        end
        tick();
        chk({tag, "_idle_ready"}, 32'(ready), 32'd1);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_idle_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_rd_cycles"}, 32'(rd_cnt - rd0), 32'(exp_rds));
        chk({tag, "_wr_cycles"}, 32'(wr_cnt - wr0), 32'(exp_wrs));
        $display("op %s: op=%0d addr=%0h wdata=%0h -> rdata=%0h carry=%0b err=%0b",
                 tag, o, a, w, rdata, carry, err);
    endtask

    initial begin
        int rd0;
        int wr0;
        int dn0;
        rst = 1'b1;
        req = 1'b0;
        op = 2'b00;
        addr = 4'h0;
        wdata = 4'h0;
        pre_en = 1'b0;
        pre_addr = 4'h0;
        pre_data = 4'h0;
        tick();
        tick();
        preset(4'h1, 4'h2);
        preset(4'h3, 4'h4);
        preset(4'h7, 4'hF);

        // Reset state
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_datain", 32'(mem_datain), 32'd0);
        chk("rst_rden", 32'(mem_read_en), 32'd0);
        chk("rst_wren", 32'(mem_write_en), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(ready), 32'd1);

        // LOAD addr 1 (preset 2): done 3 cycles after accept
        run_op("load1", 2'b00, 4'h1, 4'h0, 3, 4'h2, 1'b0, 1'b0, 1, 0);

        // Illegal op: done next cycle, err set, rdata unchanged
        run_op("illegal", 2'b11, 4'h2, 4'h6, 1, 4'h2, 1'b0, 1'b1, 0, 0);

        // STORE 9 to addr 5, err clears on accept
        run_op("store5", 2'b01, 4'h5, 4'h9, 2, 4'h2, 1'b0, 1'b0, 0, 1);
        chk("store5_wr_addr", 32'(last_wr_addr), 32'h5);
        chk("store5_wr_data", 32'(last_wr_data), 32'h9);
        run_op("load5", 2'b00, 4'h5, 4'h0, 3, 4'h9, 1'b0, 1'b0, 1, 0);

        // INC addr 3 (4 -> 5), INC addr 7 (F -> 0 with carry)
        run_op("inc3", 2'b10, 4'h3, 4'h0, 4, 4'h5, 1'b0, 1'b0, 1, 1);
        chk("inc3_wr_addr", 32'(last_wr_addr), 32'h3);
        chk("inc3_wr_data", 32'(last_wr_data), 32'h5);
        chk("inc3_ram", 32'(ram[3]), 32'h5);
        run_op("inc7", 2'b10, 4'h7, 4'h0, 4, 4'h0, 1'b1, 1'b0, 1, 1);
        chk("inc7_wr_data", 32'(last_wr_data), 32'h0);
        chk("inc7_ram", 32'(ram[7]), 32'h0);

        // req held high: exactly one accept per IDLE cycle
        rd0 = rd_cnt;
        dn0 = done_cnt;
        req = 1'b1;
        op = 2'b00;
        addr = 4'h1;
        for (int i = 0; i < 8; i++) begin
            chk("hold_ready", 32'(ready), 32'((i % 4) == 0));
            chk("hold_done", 32'(done), 32'((i % 4) == 3));
            tick();
        end
        req = 1'b0;
        chk("hold_rd_cycles", 32'(rd_cnt - rd0), 32'd2);
        chk("hold_done_count", 32'(done_cnt - dn0), 32'd2);
        chk("hold_rdata", 32'(rdata), 32'h2);
        chk("hold_idle", 32'(ready), 32'd1);
        $display("op hold_load: two LOADs of addr 1 with req held, rdata=%0h", rdata);

        // Reset during WR of INC addr 3 (holds 5)
        req = 1'b1;
        op = 2'b10;
        addr = 4'h3;
        tick();
        req = 1'b0;
        tick();
        tick();
        chk("rstwr_wren_before", 32'(mem_write_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstwr_wren_gated", 32'(mem_write_en), 32'd0);
        chk("rstwr_ready_gated", 32'(ready), 32'd0);
        wr0 = wr_cnt;
        dn0 = done_cnt;
        tick();
        chk("rstwr_ram", 32'(ram[3]), 32'h5);
        chk("rstwr_no_done", 32'(done), 32'd0);
        rst = 1'b0;
        #1;
        chk("rstwr_ready_after", 32'(ready), 32'd1);
        tick();
        chk("rstwr_no_done_later", 32'(done), 32'd0);
        chk("rstwr_wr_cycles", 32'(wr_cnt - wr0), 32'd0);
        chk("rstwr_done_count", 32'(done_cnt - dn0), 32'd0);
        chk("rstwr_addr_zero", 32'(mem_addr), 32'd0);
        $display("op rst_during_wr: INC addr 3 aborted, ram[3]=%0h", ram[3]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
